// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, Zicsr
// operation encodings, trap cause codes and mstatus bit positions.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // csr_op field from the control unit; IMM is refined by funct3
  typedef enum logic [1:0] {
    CSR_OP_RW  = 2'b00,
    CSR_OP_RS  = 2'b01,
    CSR_OP_RC  = 2'b10,
    CSR_OP_IMM = 2'b11
  } csr_op_e;

  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // mcause exception codes
  localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // addr[11:10] == 2'b11 marks a read-only CSR
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (count -> 0)
//   inc          add one this cycle (ignored when either half is written)
//   wr_lo/wr_hi  replace the low/high half with wdata
//   wdata        write data
//   count        current 64-bit value
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d (no latch).
    count_d = count_q;
    if (wr_lo) count_d[31:0]  = wdata;
    if (wr_hi) count_d[63:32] = wdata;
    // A write to either half suppresses the increment of the whole counter.
    if (!wr_lo && !wr_hi && inc) count_d = count_q + 64'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file for the single-cycle RV32I core.
// Executes Zicsr read-modify-write, trap entry (ECALL/EBREAK/illegal CSR),
// MRET, and keeps the 64-bit cycle and instret counters.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   instr_valid       current instruction executes (gates all updates but mcycle)
//   csr_addr/csr_write_enable/csr_op/csr_funct3/csr_imm   CSR command
//   rs1_data, pc      register operand, PC of the current instruction
//   ecall/ebreak/mret SYSTEM decode strobes
//   csr_rdata         old CSR value, 0 when the access is illegal
//   trap_taken        redirect PC to trap_target this cycle
//   trap_target       mtvec on a trap, mepc on mret
//   illegal_csr       current CSR access is illegal
//   irq_enable        mstatus.MIE
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [11:0] csr_addr,
  input  logic        csr_write_enable,
  input  logic [1:0]  csr_op,
  input  logic [2:0]  csr_funct3,
  input  logic [4:0]  csr_imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] pc,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic [31:0] trap_target,
  output logic        illegal_csr,
  output logic        irq_enable
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] mcycle, minstret;

  csr_op_e     op_kind;
  logic [31:0] operand, old_val, new_val;
  logic        addr_ok, do_write, trap, mret_fire, wr_en;

  // Decode, read mux and trap/return decisions
  always_comb begin
    operand = (csr_op == CSR_OP_IMM) ? {27'b0, csr_imm} : rs1_data;
    op_kind = csr_op_e'(csr_op);
    if (op_kind == CSR_OP_IMM) begin
      case (csr_funct3)
        F3_RSI:  op_kind = CSR_OP_RS;
        F3_RCI:  op_kind = CSR_OP_RC;
        default: op_kind = CSR_OP_RW;
      endcase
    end

    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_val[12:11]        = 2'b11;  // MPP hardwired to M-mode
        old_val[MSTATUS_MIE]  = mie_q;
        old_val[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MISA:                      old_val = MISA_VALUE;
      CSR_MTVEC:                     old_val = mtvec_q;
      CSR_MSCRATCH:                  old_val = mscratch_q;
      CSR_MEPC:                      old_val = mepc_q;
      CSR_MCAUSE:                    old_val = mcause_q;
      CSR_MTVAL:                     old_val = mtval_q;
      CSR_MCYCLE,   CSR_CYCLE:       old_val = mcycle[31:0];
      CSR_MINSTRET, CSR_INSTRET:     old_val = minstret[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:      old_val = mcycle[63:32];
      CSR_MINSTRETH, CSR_INSTRETH:   old_val = minstret[63:32];
      CSR_MHARTID:                   old_val = HART_ID;
      default:                       addr_ok = 1'b0;
    endcase

    // Set/clear with a zero operand is a pure read, even of read-only CSRs.
    do_write = (op_kind == CSR_OP_RW) || (operand != 32'd0);

    case (op_kind)
      CSR_OP_RS: new_val = old_val | operand;
      CSR_OP_RC: new_val = old_val & ~operand;
      default:   new_val = operand;
    endcase

    illegal_csr = csr_write_enable &&
                  (!addr_ok || (do_write && csr_is_read_only(csr_addr)));
    csr_rdata   = illegal_csr ? 32'd0 : old_val;
    trap        = instr_valid && (ecall || ebreak || illegal_csr);
    mret_fire   = instr_valid && mret && !trap;
    wr_en       = instr_valid && csr_write_enable && do_write && !trap && !mret_fire;
    trap_taken  = trap || mret_fire;
    trap_target = mret_fire ? mepc_q : mtvec_q;
  end

  // Next state of the machine CSRs
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap) begin
      mepc_d   = pc;
      mcause_d = ecall ? MCAUSE_ECALL_M : (ebreak ? MCAUSE_BREAKPOINT : MCAUSE_ILLEGAL);
      mtval_d  = '0;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_fire) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE];
          mpie_d = new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_d    = {new_val[31:2], 2'b00};  // direct mode only
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default:      ;  // misa is WARL-ignored; counters handled below
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_en && (csr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata (new_val),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_valid && !trap),
    .wr_lo (wr_en && (csr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata (new_val),
    .count (minstret)
  );

  assign irq_enable = mie_q;

endmodule
